// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the oversampling UART receiver.
//   rx_state_t  - receiver FSM state encoding (also visible on the debug port)
//   PARITY_*    - values accepted by the PARITY parameter
//   calc_div    - clocks per oversample tick (integer division)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding completed receive frames.
//   clk, reset_n  - clock, asynchronous active-low reset
//   push          - write request; accepted when not full, or when full with a pop
//   push_data     - entry to write
//   pop           - read request; ignored while empty
//   rd_data       - head entry, forced to 0 while empty
//   full, empty   - occupancy flags
//   count         - number of stored entries (0..DEPTH)
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one popped this same cycle.
  assign do_push = push && (!full || pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority-vote bit sampling,
// false-start rejection, parity/framing/break flags and an output FIFO.
//   clk, reset_n   - clock, asynchronous active-low reset
//   rx             - serial line, asynchronous, idle high
//   rx_data        - head-of-FIFO data, LSB first received
//   rx_parity_err  - head entry parity mismatch
//   rx_frame_err   - head entry had a low stop sample
//   rx_break       - head entry is a break
//   rx_valid       - FIFO not empty
//   rx_ready       - consumer takes the head entry on rx_valid && rx_ready
//   overrun        - one-clk pulse when a completed frame is dropped
//   rts_n          - 0 = peer may transmit; 1 once fill reaches RTS_THRESH
//   fsm_state      - receiver FSM state (debug)
// Handshake: an entry transfers on every clk where rx_valid && rx_ready; the
// head entry and its flags hold steady while rx_valid && !rx_ready.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int RTS_THRESH = FIFO_DEPTH - 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 rts_n,
  output rx_state_t            fsm_state
);

  localparam int DIV     = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TC_W    = $clog2(OVERSAMPLE);
  localparam int BC_W    = $clog2(DATA_BITS);
  localparam int ENTRY_W = DATA_BITS + 3;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TC_W-1:0] SAMP_A  = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0] SAMP_B  = TC_W'(OVERSAMPLE / 2);
  localparam logic [TC_W-1:0] SAMP_C  = TC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);

  // Synchroniser, reset to the idle level
  logic rx_meta, rx_sync;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Free-running oversample tick
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  assign tick = (div_cnt == DIV_W'(DIV - 1));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  rx_state_t              state, state_next;
  logic [TC_W-1:0]        tick_cnt;
  logic [BC_W-1:0]        bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   s_a, s_b;
  logic                   par_err, frame_err, par_bit;
  logic                   armed;
  logic                   decide, bit_end, maj;
  logic                   commit;
  logic                   frame_err_now, brk;
  logic [ENTRY_W-1:0]     push_data;

  assign decide  = tick && (tick_cnt == SAMP_C);
  assign bit_end = tick && (tick_cnt == TC_LAST);
  // The third sample is the live synchronised line on the decision tick.
  assign maj     = (s_a & s_b) | (s_a & rx_sync) | (s_b & rx_sync);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      ST_IDLE:   if (tick && !rx_sync && armed) state_next = ST_START;
      ST_START: begin
        if (decide && maj) state_next = ST_IDLE;
        else if (bit_end)  state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && bit_cnt == BC_W'(DATA_BITS - 1))
          state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_end) state_next = ST_STOP;
      ST_STOP: begin
        // Commit on the final stop decision, not at the end of the bit.
        if (decide && bit_cnt == BC_W'(STOP_BITS - 1)) begin
          state_next = ST_IDLE;
          commit     = 1'b1;
        end
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // Bit timing, sampling and frame assembly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      s_a       <= 1'b1;
      s_b       <= 1'b1;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      par_bit   <= 1'b0;
      armed     <= 1'b0;
    end else if (tick) begin
      if (state == ST_IDLE) begin
        if (!rx_sync && armed) begin
          // The detecting tick counts as tick 0 of the start bit.
          tick_cnt  <= TC_W'(1);
          bit_cnt   <= '0;
          par_err   <= 1'b0;
          frame_err <= 1'b0;
          par_bit   <= 1'b0;
        end else begin
          tick_cnt <= '0;
        end
        // Start detection re-arms only after the line is seen high.
        if (rx_sync) armed <= 1'b1;
      end else begin
        tick_cnt <= bit_end ? '0 : tick_cnt + TC_W'(1);
        if (tick_cnt == SAMP_A) s_a <= rx_sync;
        if (tick_cnt == SAMP_B) s_b <= rx_sync;
        if (decide) begin
          case (state)
            ST_START:  if (maj) armed <= 1'b0;
            ST_DATA:   shift <= {maj, shift[DATA_BITS-1:1]};
            ST_PARITY: begin
              par_bit <= maj;
              par_err <= (((^shift) ^ maj) != (PARITY == PARITY_ODD));
            end
            ST_STOP: begin
              if (!maj) frame_err <= 1'b1;
              if (commit) armed <= 1'b0;
            end
            default: ;
          endcase
        end
        if (bit_end) begin
          if (state == ST_DATA)
            bit_cnt <= (bit_cnt == BC_W'(DATA_BITS - 1)) ? '0 : bit_cnt + BC_W'(1);
          else if (state == ST_STOP)
            bit_cnt <= bit_cnt + BC_W'(1);
        end
      end
    end
  end

  // Frame flags include the stop sample being decided this cycle.
  assign frame_err_now = frame_err | !maj;
  assign brk = frame_err_now && (shift == '0) && ((PARITY == PARITY_NONE) || !par_bit);
  assign push_data = {brk, frame_err_now, par_err, shift};

  logic               pop, full, empty, push_ok;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   fill, fill_next;

  assign pop     = rx_ready && !empty;
  assign push_ok = commit && (!full || pop);

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (commit),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (head),
    .full      (full),
    .empty     (empty),
    .count     (fill)
  );

  assign rx_valid      = !empty;
  assign rx_data       = head[DATA_BITS-1:0];
  assign rx_parity_err = head[DATA_BITS];
  assign rx_frame_err  = head[DATA_BITS+1];
  assign rx_break      = head[DATA_BITS+2];

  // rts_n tracks the fill level as it will be after this cycle's push/pop.
  assign fill_next = fill + CNT_W'(push_ok) - CNT_W'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
      rts_n   <= 1'b1;
    end else begin
      overrun <= commit && full && !pop;
      rts_n   <= (fill_next >= CNT_W'(RTS_THRESH));
    end
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver. It is the successor to the team's fixed 8N1 receiver and adds configurable frame format, majority-vote sampling, false-start rejection, parity/framing/break detection, and an output FIFO with valid/ready handshake. RTS flow control is driven from FIFO fill level. It sits between the board RX pin and the byte-consuming logic (command parser, loopback, LED demos).

Parameters:
CLK_FREQ, 12000000, system clock in Hz
BAUD_RATE, 115200, line rate in baud
OVERSAMPLE, 8, sample ticks per bit; even, >= 4
DATA_BITS, 8, data bits per frame; 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, output FIFO entries; power of 2, >= 2
RTS_THRESH, FIFO_DEPTH-1, fill level at or above which rts_n deasserts

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
rx  in  1  serial input, asynchronous to clk, idle high
rx_data  out  DATA_BITS  head-of-FIFO data, LSB = first bit received
rx_parity_err  out  1  head entry had a parity mismatch
rx_frame_err  out  1  head entry had a stop bit sampled low
rx_break  out  1  head entry is a break (all data 0, parity 0 if enabled, stop 0)
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer accepts head entry when rx_valid && rx_ready
overrun  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full
rts_n  out  1  active-low request-to-send: 0 = peer may transmit

Behaviour:
- Reset (async, reset_n = 0): FSM to IDLE, all counters 0, FIFO empty, rx synchroniser flops = 1, rx_valid = 0, overrun = 0, rts_n = 1. rx_data and flag outputs read 0 while the FIFO is empty.
- Synchroniser: 2-flop on rx. All logic uses the synchronised signal (2-cycle input latency).
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division (13 at defaults). A one-clk tick pulse fires every DIV clks. The divider runs freely, so the bit period is DIV*OVERSAMPLE clks (104 at defaults).
- Per-bit sample: majority of 3 samples taken on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit. The bit decision is made on the last of those three ticks.
- FSM states:
  - IDLE: a tick with sync rx = 0 goes to START, with tick count reset to 1.
  - START: at the decision point, if majority = 1 this is a false start: return to IDLE and push nothing. Otherwise go to DATA at the end of the bit.
  - DATA: shift in DATA_BITS bits, LSB first. Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: compare the received bit against the computed parity (odd means total 1s, data plus parity, is odd). A mismatch sets a latched parity_err.
  - STOP: sample STOP_BITS stop bits; any stop sample of 0 sets frame_err. At the decision point of the final stop bit, commit the frame and return to IDLE immediately, without waiting for the end of the bit.
- Commit: write {break, frame_err, parity_err, data} to the FIFO. break = frame_err && data == 0 && (PARITY == 0 || parity bit == 0).
  - Frames with errors are still pushed.
  - If the FIFO is full and no pop occurs that cycle: drop the frame and pulse overrun for 1 clk.
  - Push and pop in the same cycle while full: the push is accepted.
- Latency: rx_valid rises the clk after the commit edge.
- FIFO handshake: rx_data and flags are stable while rx_valid && !rx_ready. Pop happens on a clk with rx_valid && rx_ready. Pointers wrap modulo FIFO_DEPTH. A pop while empty is ignored.
- rts_n is registered: next value = (fill_count >= RTS_THRESH), computed after the push/pop of that cycle. It becomes 0 on the first clk after reset release with an empty FIFO.
- Reset mid-frame: the partial frame is discarded. The FSM re-arms in IDLE and does not detect a start until sync rx has been seen high.
- A line held low after a break does not re-trigger: IDLE requires one tick with sync rx = 1 before it arms start detection again.

Decomposition:
- Package uart_pkg: FSM state encoding, PARITY_NONE/ODD/EVEN constants, tick divider function (clk/baud/os -> DIV).
- Sub-module uart_rx_fifo: synchronous FIFO parametrised by WIDTH and DEPTH. Provides push/pop/full/empty/count. The receiver FSM, synchroniser and tick generator stay in uart_rx_os.

Test Plan:
- Defaults, send 0xA5 8N1 at 104 clks/bit, rx_ready = 1 -> rx_valid pulses 1 clk with rx_data = 0xA5, all flags 0, no overrun.
- PARITY = 2: send 0x3C with parity bit 1 -> rx_data = 0x3C, rx_parity_err = 1. Same byte with parity bit 0 -> rx_parity_err = 0.
- rx low glitch of 20 clks, then idle -> no FIFO push, rx_valid stays 0, FSM back in IDLE.
- Send 0x00 with stop bit 0 -> rx_frame_err = 1 and rx_break = 1. Send 0x41 with stop bit 0 -> rx_frame_err = 1, rx_break = 0.
- FIFO_DEPTH = 4, RTS_THRESH = 3, rx_ready = 0, send 5 bytes 0x01..0x05:
  - rts_n goes 1 after the 3rd commit; overrun pulses once on the 5th frame.
  - Draining then yields 0x01..0x04 in order, and rts_n returns to 0 when fill < 3.
- Assert reset_n = 0 mid-DATA of 0x55, release, send 0x99 -> only 0x99 appears, rts_n = 1 during reset and 0 one clk after release.
